alu_issue_ctrl: RTL and testbench

Sequencing front end for the KGP-RISC ALU: accepts one decoded instruction (opcode, func, shamt, operand values) per handshake, translates it into the ALU's 4-bit op code, drives registered operands into the combinational ALU, and captures the result and flags one cycle later. It also owns the architectural flag register (zero, sign, carry) consumed by branch logic. It sits between register-read and write-back.

---
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Purpose: decode one instruction per handshake into an ALU op, register operands, capture result and flags.
// Latency: accept cycle -> EXEC -> DONE; the result is presented in the second cycle after the accept cycle.
// Backpressure: in_ready is high only in IDLE; DONE holds res_valid/res_data/res_err/flags until res_ready.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_func,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        alu_carry,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        flag_z,
  output logic        flag_s,
  output logic        flag_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // ALU op encodings; 0000 makes the ALU forward operand a.
  localparam logic [3:0] OP_PASS  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_DIFF  = 4'b0100;
  localparam logic [3:0] OP_COMP  = 4'b0101;
  localparam logic [3:0] OP_SHLLV = 4'b1000;
  localparam logic [3:0] OP_SHRLV = 4'b1001;
  localparam logic [3:0] OP_SHRAV = 4'b1010;
  localparam logic [3:0] OP_SHLL  = 4'b1100;
  localparam logic [3:0] OP_SHRL  = 4'b1101;
  localparam logic [3:0] OP_SHRA  = 4'b1110;

  state_t     state;
  state_t     nextState;
  logic [3:0] decOp;
  logic       decIllegal;
  logic       accept;
  logic       errReg;

  assign accept  = in_valid && (state == IDLE);
  assign res_err = errReg;

  // Translate opcode/func into the ALU op code; anything unrecognised is flagged illegal.
  always_comb begin
    decOp      = OP_PASS;
    decIllegal = 1'b0;
    case (in_opcode)
      6'b000000: begin
        case (in_func)
          5'b00000: decOp = OP_ADD;
          5'b00001: decOp = OP_COMP;
          5'b00010: decOp = OP_AND;
          5'b00011: decOp = OP_XOR;
          5'b00100: decOp = OP_DIFF;
          5'b01000: decOp = OP_SHLL;
          5'b01001: decOp = OP_SHRL;
          5'b01010: decOp = OP_SHRA;
          5'b01100: decOp = OP_SHLLV;
          5'b01101: decOp = OP_SHRLV;
          5'b01110: decOp = OP_SHRAV;
          default:  decIllegal = 1'b1;
        endcase
      end
      6'b000001: decOp = OP_ADD;
      6'b000010: decOp = OP_AND;
      6'b000011: decOp = OP_XOR;
      default:   decIllegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and handshake outputs.
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nextState = EXEC;
      end
      EXEC: nextState = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand/op registers load only on accept so the ALU inputs hold between instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_PASS;
      alu_shamt <= '0;
      errReg    <= 1'b0;
    end else if (accept) begin
      alu_a     <= in_a;
      alu_b     <= in_b;
      alu_op    <= decOp;
      alu_shamt <= in_shamt;
      errReg    <= decIllegal;
    end
  end

  // Capture the settled ALU result and, for legal ops, the flags at the end of EXEC.
  // Carry is architecturally defined only by add, so every other op leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      flag_z   <= 1'b0;
      flag_s   <= 1'b0;
      flag_c   <= 1'b0;
    end else if (state == EXEC) begin
      res_data <= alu_result;
      if (!errReg) begin
        flag_z <= alu_zero;
        flag_s <= alu_sign;
        if (alu_op == OP_ADD) flag_c <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU wired to the alu_* ports.
// Stimulus pushes hand-computed expectations; a negedge monitor pops on each new result.
// Covers reset state, decode, flag retention, illegal ops, back-pressure and reset mid-flight.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_func;
  logic [4:0]  in_shamt;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_sign;
  logic        alu_carry;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        flag_z;
  logic        flag_s;
  logic        flag_c;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func(in_func), .in_shamt(in_shamt),
    .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c)
  );

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        err;
    logic [3:0]  op;
    logic        z;
    logic        s;
    logic        c;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  int   nextId = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: carry is produced only by add so that carry retention is observable.
  logic [32:0] sum;
  always_comb begin
    sum        = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = alu_a;
    alu_carry  = 1'b0;
    case (alu_op)
      4'b0001: begin alu_result = sum[31:0]; alu_carry = sum[32]; end
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a ^ alu_b;
      4'b0100: alu_result = alu_a - alu_b;
      4'b0101: alu_result = ~alu_b + 32'd1;
      4'b1000: alu_result = alu_a << alu_b[4:0];
      4'b1001: alu_result = alu_a >> alu_b[4:0];
      4'b1010: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b1100: alu_result = alu_a << alu_shamt;
      4'b1101: alu_result = alu_a >> alu_shamt;
      4'b1110: alu_result = $unsigned($signed(alu_a) >>> alu_shamt);
      default: alu_result = alu_a;
    endcase
    alu_zero = (alu_result == 32'd0);
    alu_sign = alu_result[31];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: got timeout, required DUT event", name);
  endtask

  // Present one instruction, wait for acceptance, push its expectation.
  task automatic issue(input logic [5:0] opc, input logic [4:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic er, input logic [3:0] op,
                       input logic z, input logic s, input logic c);
    exp_t x;
    int   budget;
    @(posedge clk); #1;
    in_opcode = opc; in_func = fn; in_shamt = sh; in_a = a; in_b = b; in_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin budget++; @(negedge clk); end
    if (budget >= 50) timeout("accept_wait");
    else begin
      x.id = nextId; x.res = r; x.err = er; x.op = op; x.z = z; x.s = s; x.c = c; x.acc = cyc;
      nextId++;
      q.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    @(negedge clk);
    while ((q.size() != 0 || res_valid) && budget < 100) begin budget++; @(negedge clk); end
    if (budget >= 100) timeout("drain");
  endtask

  // Monitor: each rising res_valid is a new result; compare it with the oldest expectation.
  exp_t e;
  bit   presented = 1'b0;
  always @(negedge clk) begin
    if (rst) presented = 1'b0;
    else if (res_valid && !presented) begin
      presented = 1'b1;
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_result: got res_data 0x%08h, required no result", res_data);
      end else begin
        e = q.pop_front();
        check($sformatf("v%0d res_data", e.id), res_data, e.res);
        check($sformatf("v%0d res_err", e.id), 32'(res_err), 32'(e.err));
        check($sformatf("v%0d alu_op", e.id), 32'(alu_op), 32'(e.op));
        check($sformatf("v%0d flag_z", e.id), 32'(flag_z), 32'(e.z));
        check($sformatf("v%0d flag_s", e.id), 32'(flag_s), 32'(e.s));
        check($sformatf("v%0d flag_c", e.id), 32'(flag_c), 32'(e.c));
        check($sformatf("v%0d latency", e.id), 32'(cyc), 32'(e.acc + 2));
      end
    end else if (!res_valid) presented = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int hsCyc;
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
    in_opcode = '0; in_func = '0; in_shamt = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then idle with in_valid low.
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data", res_data, 32'd0);
    check("rst res_err", 32'(res_err), 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst alu_shamt", 32'(alu_shamt), 32'd0);
    check("rst flags", 32'({flag_z, flag_s, flag_c}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle in_ready", 32'(in_ready), 32'd1);
      check("idle res_valid", 32'(res_valid), 32'd0);
    end

    //    opc        func      sh     a             b             result        err   op       z     s     c
    issue(6'b000000, 5'b00000, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
    issue(6'b000000, 5'b00001, 5'd0,  32'h00000000, 32'h00000005, 32'hFFFFFFFB, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b1);
    issue(6'b000000, 5'b01010, 5'd4,  32'h80000000, 32'h00000000, 32'hF8000000, 1'b0, 4'b1110, 1'b0, 1'b1, 1'b1);
    issue(6'b000000, 5'b01100, 5'd0,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1);
    issue(6'b000000, 5'b00000, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1);
    issue(6'b111111, 5'b00000, 5'd0,  32'h12345678, 32'h00000001, 32'h12345678, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    issue(6'b000000, 5'b11111, 5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    issue(6'b000001, 5'b00000, 5'd0,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    issue(6'b000011, 5'b00000, 5'd0,  32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
    issue(6'b000010, 5'b00000, 5'd0,  32'h80000000, 32'h80000001, 32'h80000000, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0);
    issue(6'b000000, 5'b01000, 5'd31, 32'h00000003, 32'h00000000, 32'h80000000, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b0);
    issue(6'b000000, 5'b01001, 5'd31, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-pressure: hold res_ready low 5 cycles while a second op waits on in_valid.
    res_ready = 1'b0;
    issue(6'b000000, 5'b00010, 5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    in_opcode = 6'b000000; in_func = 5'b00011; in_a = 32'hAAAA5555; in_b = 32'h0000FFFF;
    in_valid = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!res_valid && budget < 20) begin budget++; @(negedge clk); end
    if (budget >= 20) timeout("bp res_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp res_valid", 32'(res_valid), 32'd1);
      check("bp res_data", res_data, 32'h0F000F00);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp alu_op", 32'(alu_op), 32'b0010);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    check("bp hs res_valid", 32'(res_valid), 32'd1);
    hsCyc = cyc;
    @(negedge clk);
    check("bp next in_ready", 32'(in_ready), 32'd1);
    check("bp next accept cycle", 32'(cyc), 32'(hsCyc + 1));
    if (in_ready) begin
      e.id = nextId; e.res = 32'hAAAAAAAA; e.err = 1'b0; e.op = 4'b0011;
      e.z = 1'b0; e.s = 1'b1; e.c = 1'b0; e.acc = cyc;
      nextId++;
      q.push_back(e);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain();

    // Set nonzero flags, then reset while an xor is in EXEC.
    issue(6'b000000, 5'b00000, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
    drain();
    @(posedge clk); #1;
    in_opcode = 6'b000000; in_func = 5'b00011; in_a = 32'h0000FFFF; in_b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    check("rx accept ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rx in_ready", 32'(in_ready), 32'd1);
    check("rx res_valid", 32'(res_valid), 32'd0);
    check("rx res_data", res_data, 32'd0);
    check("rx res_err", 32'(res_err), 32'd0);
    check("rx flags", 32'({flag_z, flag_s, flag_c}), 32'd0);
    check("rx alu_a", alu_a, 32'd0);
    check("rx alu_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rx no result", 32'(res_valid), 32'd0);
    end

    issue(6'b000001, 5'b00000, 5'd0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    drain();
    check("queue empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
